// File: rtl/divider_top.sv
// Sequential unsigned restoring divider: one quotient bit per clock,
// start/done handshake, results held until the next completion.
module divider_step #(
  parameter int W = 6
) (
  input  logic [W-1:0] p_i,
  input  logic [W-1:0] quo_i,
  input  logic [W-1:0] div_i,
  output logic [W-1:0] p_o,
  output logic [W-1:0] quo_o
);
  logic [W:0]   shifted;
  logic [W+1:0] diff;
  logic         take;

  // One extra sign bit so the borrow out of the (W+1)-bit subtract is visible.
  assign shifted = {p_i, quo_i[W-1]};
  assign diff    = {1'b0, shifted} - {2'b00, div_i};
  assign take    = ~diff[W+1];
  assign p_o     = take ? diff[W-1:0] : shifted[W-1:0];
  assign quo_o   = {quo_i[W-2:0], take};
endmodule

module divider_top #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {S_IDLE, S_RUN} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] div_q, p_q, quo_q;
  logic [WIDTH-1:0] p_d, quo_d;
  logic [CW-1:0]    cnt_q;
  logic             busy_q, done_q, dbz_q;
  logic [WIDTH-1:0] q_q, r_q;

  divider_step #(.W(WIDTH)) u_step (
    .p_i   (p_q),
    .quo_i (quo_q),
    .div_i (div_q),
    .p_o   (p_d),
    .quo_o (quo_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      p_q     <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            div_q   <= b;
            p_q     <= '0;
            quo_q   <= a;
            cnt_q   <= CW'(WIDTH);
            busy_q  <= 1'b1;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          p_q   <= p_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            // Divide by zero takes the normal path: every step "fits".
            q_q     <= quo_d;
            r_q     <= p_d;
            dbz_q   <= (div_q == '0);
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign q           = q_q;
  assign r           = r_q;
  assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_divider_top.sv
// Self-checking bench for divider_top: directed corners, back-to-back,
// mid-op reset, random ops and an exhaustive sweep against a/b, a%b.
module tb_divider_top;
  localparam int W = 6;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         busy, done, dbz;
  logic [W-1:0] q, r;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  divider_top #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .q           (q),
    .r           (r),
    .div_by_zero (dbz)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division; b==0 gives all-ones quotient, r=a.
  function automatic void ref_div(input int ea, input int eb,
                                  output int eq, output int er, output int ez);
    if (eb == 0) begin
      eq = (1 << W) - 1; er = ea; ez = 1;
    end else begin
      eq = ea / eb; er = ea % eb; ez = 0;
    end
  endfunction

  // Call at a negedge with the divider idle. Leaves the bench at the negedge
  // where done is seen, so a following call starts back-to-back.
  task automatic op(input int ea, input int eb, input bit hold, input bit full);
    int lat, eq, er, ez;
    a = ea[W-1:0]; b = eb[W-1:0]; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (!hold) start = 1'b0;
    a = W'($urandom); b = W'($urandom);
    if (full) chk("busy_after_start", {31'd0, busy}, 32'd1);
    lat = 0;
    while (!done && lat < 3 * W) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    ref_div(ea, eb, eq, er, ez);
    if (full) begin
      chk("latency", lat, W);
      chk("busy_at_done", {31'd0, busy}, 32'd0);
    end else if (!done) chk("done_timeout", lat, W);
    chk($sformatf("q %0d/%0d", ea, eb), {26'd0, q}, eq);
    chk($sformatf("r %0d%%%0d", ea, eb), {26'd0, r}, er);
    chk($sformatf("dbz %0d/%0d", ea, eb), {31'd0, dbz}, ez);
  endtask

  initial begin
    int pulses, lq, lr;
    #2;
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_q", {26'd0, q}, 0);
    chk("rst_r", {26'd0, r}, 0);
    chk("rst_dbz", {31'd0, dbz}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    op(45, 7, 0, 1);
    op(63, 1, 0, 1);
    op(0, 5, 0, 1);
    op(5, 9, 0, 1);
    op(20, 0, 0, 1);
    op(63, 63, 0, 1);
    op(62, 63, 0, 1);

    // Idle with start low: outputs hold, no done.
    @(negedge clk);
    lq = q; lr = r; pulses = 0;
    for (int i = 0; i < 5; i++) begin
      a = W'($urandom); b = W'($urandom);
      @(negedge clk);
      if (done) pulses++;
    end
    chk("idle_done", pulses, 0);
    chk("idle_q", {26'd0, q}, lq);
    chk("idle_r", {26'd0, r}, lr);
    chk("idle_busy", {31'd0, busy}, 0);

    // start held high: back-to-back, inputs scrambled while busy.
    op(50, 6, 1, 1);
    op(33, 4, 1, 1);
    op(17, 0, 1, 1);
    op(9, 2, 0, 1);

    // Reset in the middle of a division.
    @(negedge clk);
    a = 6'd45; b = 6'd7; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", {31'd0, busy}, 0);
    chk("midrst_done", {31'd0, done}, 0);
    chk("midrst_q", {26'd0, q}, 0);
    chk("midrst_r", {26'd0, r}, 0);
    chk("midrst_dbz", {31'd0, dbz}, 0);
    pulses = 0;
    repeat (2) begin @(negedge clk); if (done) pulses++; end
    rst_n = 1'b1;
    repeat (3 * W) begin @(negedge clk); if (done) pulses++; end
    chk("midrst_no_done", pulses, 0);
    op(45, 7, 0, 1);

    // Random operations, including divisor zero.
    for (int i = 0; i < 200; i++) begin
      int ra, rb;
      ra = int'($urandom_range(0, 63));
      rb = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 63));
      op(ra, rb, $urandom_range(0, 1) == 1, 1);
    end
    start = 1'b0;
    @(negedge clk);

    // Exhaustive sweep over nonzero divisors.
    for (int ea = 0; ea < 64; ea++)
      for (int eb = 1; eb < 64; eb++)
        op(ea, eb, 1, 0);
    start = 1'b0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
